// File: rtl/cache_ctrl.sv
// rtl/cache_ctrl.sv - direct-mapped, write-through, no-write-allocate cache sequencer for a 32-line x 4-word array.
// Optional hit/miss counters are built when CACHE_STATS_EN is defined.
module cache_ctrl #(
    parameter int ADDR_WIDTH  = 32,
    parameter int INDEX_WIDTH = 5,
    parameter int TAG_WIDTH   = ADDR_WIDTH - INDEX_WIDTH - 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   cpu_req,
    input  logic                   cpu_we,
    input  logic [ADDR_WIDTH-1:0]  cpu_addr,
    input  logic [31:0]            cpu_wdata,
    output logic                   cpu_ready,
    input  logic                   cache_flush,
    output logic                   cache_read,
    output logic                   cache_update,
    output logic                   cache_refill,
    output logic [INDEX_WIDTH+1:0] cache_index_offset,
    output logic                   mem_req,
    output logic                   mem_we,
    output logic [ADDR_WIDTH-1:0]  mem_addr,
    output logic [31:0]            mem_wdata,
    input  logic                   mem_ack
`ifdef CACHE_STATS_EN
    ,
    output logic [31:0]            stat_hits,
    output logic [31:0]            stat_misses
`endif
);

    localparam int LINES = 1 << INDEX_WIDTH;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_MISS = 2'd1,
        WR_THRU = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_next;
    logic [LINES-1:0]       r_valid;
    logic [TAG_WIDTH-1:0]   r_tag [LINES];
    logic                   r_replay;

    logic [INDEX_WIDTH-1:0] w_index;
    logic [TAG_WIDTH-1:0]   w_tag;
    logic                   w_hit;
    logic                   w_flush;
    logic                   w_fill;
    logic                   w_unused_addr;

    assign w_index            = cpu_addr[INDEX_WIDTH+3:4];
    assign w_tag              = cpu_addr[ADDR_WIDTH-1:INDEX_WIDTH+4];
    assign w_hit              = r_valid[w_index] && (r_tag[w_index] == w_tag);
    assign cache_index_offset = cpu_addr[INDEX_WIDTH+3:2];
    assign mem_wdata          = cpu_wdata;
    assign w_unused_addr      = ^cpu_addr[1:0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= IDLE;
            r_valid  <= '0;
            r_replay <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_replay <= w_fill;
            if (w_flush) begin
                r_valid <= '0;
            end else if (w_fill) begin
                r_valid[w_index] <= 1'b1;
            end
        end
    end

    // Tag contents are meaningless while the valid bit is clear, so they need no reset.
    always_ff @(posedge clk) begin
        if (w_fill) begin
            r_tag[w_index] <= w_tag;
        end
    end

    always_comb begin
        w_next       = r_state;
        cpu_ready    = 1'b0;
        cache_read   = 1'b0;
        cache_update = 1'b0;
        cache_refill = 1'b0;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = '0;
        w_flush      = 1'b0;
        w_fill       = 1'b0;
        case (r_state)
            IDLE: begin
                if (cache_flush) begin
                    w_flush = 1'b1;
                end else if (cpu_req) begin
                    if (cpu_we) begin
                        w_next = WR_THRU;
                    end else if (w_hit) begin
                        cache_read = 1'b1;
                        cpu_ready  = 1'b1;
                    end else begin
                        w_next = RD_MISS;
                    end
                end
            end
            RD_MISS: begin
                mem_req  = 1'b1;
                mem_addr = {cpu_addr[ADDR_WIDTH-1:4], 4'b0000};
                if (mem_ack) begin
                    cache_refill = 1'b1;
                    w_fill       = 1'b1;
                    w_next       = IDLE;
                end
            end
            WR_THRU: begin
                mem_req  = 1'b1;
                mem_we   = 1'b1;
                mem_addr = {cpu_addr[ADDR_WIDTH-1:2], 2'b00};
                if (mem_ack) begin
                    cpu_ready    = 1'b1;
                    cache_update = w_hit;
                    w_next       = IDLE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

`ifdef CACHE_STATS_EN
    logic w_count_hit;
    logic w_count_miss;

    // The load that completes right after a refill is a replay of a counted miss.
    assign w_count_hit  = cache_read && !r_replay;
    assign w_count_miss = (r_state == IDLE) && (w_next == RD_MISS);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stat_hits   <= '0;
            stat_misses <= '0;
        end else begin
            if (w_count_hit && (stat_hits != 32'hFFFF_FFFF)) begin
                stat_hits <= stat_hits + 32'd1;
            end
            if (w_count_miss && (stat_misses != 32'hFFFF_FFFF)) begin
                stat_misses <= stat_misses + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_cache_ctrl.sv
// tb/tb_cache_ctrl.sv - scoreboard bench for cache_ctrl with memory responder and cache array model.
module tb_cache_ctrl;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         cpu_req = 1'b0;
    logic         cpu_we = 1'b0;
    logic [31:0]  cpu_addr = '0;
    logic [31:0]  cpu_wdata = '0;
    logic         cpu_ready;
    logic         cache_flush = 1'b0;
    logic         cache_read;
    logic         cache_update;
    logic         cache_refill;
    logic [6:0]   cache_index_offset;
    logic         mem_req;
    logic         mem_we;
    logic [31:0]  mem_addr;
    logic [31:0]  mem_wdata;
    logic         mem_ack = 1'b0;
    logic [127:0] mem_rdata = '0;
`ifdef CACHE_STATS_EN
    logic [31:0]  stat_hits;
    logic [31:0]  stat_misses;
`endif

    cache_ctrl dut (
        .clk(clk), .reset_n(reset_n), .cpu_req(cpu_req), .cpu_we(cpu_we),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_ready(cpu_ready),
        .cache_flush(cache_flush), .cache_read(cache_read), .cache_update(cache_update),
        .cache_refill(cache_refill), .cache_index_offset(cache_index_offset),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack)
`ifdef CACHE_STATS_EN
        , .stat_hits(stat_hits), .stat_misses(stat_misses)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] data;
        int          lat;
        int          n_mem;
        logic [31:0] maddr;
        int          n_upd;
        int          n_ref;
        int          t_start;
    } exp_t;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_pass = 0;
    int          cyc = 0;
    int          next_d = 0;
    bit          resp_en = 1'b1;

    logic [31:0] arr [128];
    logic [31:0] resp_mem [logic [31:0]];
    logic [31:0] ref_mem  [logic [31:0]];
    bit   [31:0] ref_valid = '0;
    logic [22:0] ref_tag [32];
    int          ref_hits = 0;
    int          ref_misses = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic finish_run();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    endtask

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h1234_5678;
    endfunction

    function automatic logic [31:0] ref_word(input logic [31:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return init_word(a);
    endfunction

    function automatic logic [31:0] resp_word(input logic [31:0] a);
        if (resp_mem.exists(a)) return resp_mem[a];
        return init_word(a);
    endfunction

    always @(posedge clk) cyc++;

    // Main memory: acks after next_d extra cycles of mem_req, writes on the ack.
    initial begin
        bit busy = 1'b0;
        bit acking = 1'b0;
        int cnt = 0;
        forever begin
            @(posedge clk);
            #2;
            if (acking) begin
                mem_ack = 1'b0;
                acking  = 1'b0;
                busy    = 1'b0;
            end else if (mem_req && resp_en && reset_n) begin
                if (!busy) begin
                    busy = 1'b1;
                    cnt  = next_d;
                end
                if (cnt == 0) begin
                    mem_ack = 1'b1;
                    acking  = 1'b1;
                    if (mem_we) begin
                        resp_mem[mem_addr] = mem_wdata;
                    end else begin
                        for (int k = 0; k < 4; k++)
                            mem_rdata[32*k +: 32] = resp_word({mem_addr[31:4], k[1:0], 2'b00});
                    end
                end else begin
                    cnt--;
                end
            end else if (!reset_n) begin
                busy = 1'b0;
            end
        end
    end

    // Monitor: pops the expected response when the DUT completes an access.
    initial begin
        int   acc_mem = 0;
        int   acc_upd = 0;
        int   acc_ref = 0;
        logic prev_req = 1'b0;
        logic prev_we = 1'b0;
        logic [31:0] prev_addr = '0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset_n) continue;
            if (!cpu_req) begin
                acc_mem = 0;
                acc_upd = 0;
                acc_ref = 0;
            end
            if (cache_update && cache_refill) chk("update_refill_exclusive", 32'd1, 32'd0);
            if (mem_req) begin
                if (!prev_req) begin
                    acc_mem++;
                    if (exp_q.size() > 0) begin
                        chk("mem_addr", mem_addr, exp_q[0].maddr);
                        chk("mem_we", {31'b0, mem_we}, {31'b0, exp_q[0].we});
                    end
                end else begin
                    chk("mem_addr_stable", mem_addr, prev_addr);
                    chk("mem_we_stable", {31'b0, mem_we}, {31'b0, prev_we});
                end
            end
            prev_req  = mem_req;
            prev_we   = mem_we;
            prev_addr = mem_addr;
            if (cache_update) acc_upd++;
            if (cache_refill) acc_ref++;
            if (cpu_ready) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_ready", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("latency", cyc - e.t_start, e.lat);
                    chk("mem_req_count", acc_mem, e.n_mem);
                    chk("update_count", acc_upd, e.n_upd);
                    chk("refill_count", acc_ref, e.n_ref);
                    if (!e.we) begin
                        chk("cache_read", {31'b0, cache_read}, 32'd1);
                        chk("load_data", arr[cache_index_offset], e.data);
                    end
                end
                acc_mem = 0;
                acc_upd = 0;
                acc_ref = 0;
            end
            if (cache_refill)
                for (int k = 0; k < 4; k++)
                    arr[{cache_index_offset[6:2], k[1:0]}] = mem_rdata[32*k +: 32];
            if (cache_update) arr[cache_index_offset] = cpu_wdata;
        end
    end

    task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] data,
                          input int d, input bit with_flush);
        exp_t        e;
        logic [4:0]  idx;
        logic [22:0] tg;
        bit          hit;
        bit          done = 1'b0;
        idx = addr[8:4];
        tg  = addr[31:9];
        if (with_flush) ref_valid = '0;
        hit = ref_valid[idx] && (ref_tag[idx] == tg);
        e.we    = we;
        e.lat   = (we ? d + 1 : (hit ? 0 : d + 2)) + (with_flush ? 1 : 0);
        e.n_mem = (we || !hit) ? 1 : 0;
        e.maddr = we ? {addr[31:2], 2'b00} : {addr[31:4], 4'h0};
        e.n_upd = (we && hit) ? 1 : 0;
        e.n_ref = (!we && !hit) ? 1 : 0;
        e.data  = we ? 32'h0 : ref_word({addr[31:2], 2'b00});
        if (we) begin
            ref_mem[{addr[31:2], 2'b00}] = data;
        end else if (hit) begin
            ref_hits++;
        end else begin
            ref_misses++;
            ref_valid[idx] = 1'b1;
            ref_tag[idx]   = tg;
        end
        @(posedge clk);
        #1;
        cpu_req     = 1'b1;
        cpu_we      = we;
        cpu_addr    = addr;
        cpu_wdata   = data;
        cache_flush = with_flush;
        next_d      = d;
        e.t_start   = cyc;
        exp_q.push_back(e);
        if (with_flush) begin
            @(posedge clk);
            #1;
            cache_flush = 1'b0;
        end
        for (int k = 0; k < 60 && !done; k++) begin
            @(negedge clk);
            if (cpu_ready) done = 1'b1;
        end
        if (!done) begin
            n_checks++;
            $display("FAIL access_timeout: got no cpu_ready expected ready within 60 cycles (addr %h)", addr);
            finish_run();
        end
        @(posedge clk);
        #1;
        cpu_req = 1'b0;
    endtask

    task automatic flush_pulse();
        @(posedge clk);
        #1;
        cache_flush = 1'b1;
        ref_valid   = '0;
        @(posedge clk);
        #1;
        cache_flush = 1'b0;
    endtask

    initial begin
        int          op;
        logic [31:0] a;
        bit          seen;
        #3;
        chk("rst_cpu_ready", {31'b0, cpu_ready}, 32'd0);
        chk("rst_cache_read", {31'b0, cache_read}, 32'd0);
        chk("rst_cache_update", {31'b0, cache_update}, 32'd0);
        chk("rst_cache_refill", {31'b0, cache_refill}, 32'd0);
        chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
        chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;

        access(1'b0, 32'h0000_0104, 32'h0, 3, 1'b0);
        chk("index_offset_0x104", {25'b0, cache_index_offset}, 32'h41);
        access(1'b0, 32'h0000_0108, 32'h0, 0, 1'b0);
        access(1'b0, 32'h0000_0304, 32'h0, 1, 1'b0);
        access(1'b0, 32'h0000_0104, 32'h0, 2, 1'b0);
        access(1'b1, 32'h0000_0104, 32'hDEAD_BEEF, 2, 1'b0);
        access(1'b0, 32'h0000_0104, 32'h0, 0, 1'b0);
        access(1'b1, 32'h0000_0A40, 32'h1357_9BDF, 0, 1'b0);
        access(1'b0, 32'h0000_0108, 32'h0, 0, 1'b0);
        flush_pulse();
        access(1'b0, 32'h0000_0108, 32'h0, 1, 1'b0);
        access(1'b0, 32'h0000_0108, 32'h0, 0, 1'b1);

        for (int n = 0; n < 160; n++) begin
            op = $urandom_range(0, 99);
            a  = {9'b0, 14'($urandom_range(0, 2)), 5'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'b00};
            if (op < 6) flush_pulse();
            else access(op < 65 ? 1'b0 : 1'b1, a, $urandom, $urandom_range(0, 4), op >= 94);
        end

`ifdef CACHE_STATS_EN
        chk("stat_hits", stat_hits, ref_hits);
        chk("stat_misses", stat_misses, ref_misses);
`endif

        flush_pulse();
        resp_en = 1'b0;
        @(posedge clk);
        #1;
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = 32'h0000_4040;
        seen     = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            @(negedge clk);
            if (mem_req) seen = 1'b1;
        end
        chk("rdmiss_mem_req_seen", {31'b0, seen}, 32'd1);
        #1;
        reset_n = 1'b0;
        #1;
        chk("reset_drops_mem_req", {31'b0, mem_req}, 32'd0);
        chk("reset_no_refill", {31'b0, cache_refill}, 32'd0);
        cpu_req = 1'b0;
        @(posedge clk);
        #1;
        reset_n    = 1'b1;
        resp_en    = 1'b1;
        ref_valid  = '0;
        ref_hits   = 0;
        ref_misses = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("post_reset_refill", {31'b0, cache_refill}, 32'd0);
            chk("post_reset_mem_req", {31'b0, mem_req}, 32'd0);
        end
        access(1'b0, 32'h0000_4040, 32'h0, 1, 1'b0);
        access(1'b0, 32'h0000_4044, 32'h0, 0, 1'b0);
        access(1'b0, 32'h0000_4048, 32'h0, 0, 1'b0);
        access(1'b1, 32'h0000_4048, 32'h0BAD_F00D, 1, 1'b0);

`ifdef CACHE_STATS_EN
        chk("stat_hits_after_reset", stat_hits, ref_hits);
        chk("stat_misses_after_reset", stat_misses, ref_misses);
`endif

        repeat (3) @(posedge clk);
        chk("queue_drained", exp_q.size(), 32'd0);
        finish_run();
    end

    initial begin
        #200000;
        n_checks++;
        $display("FAIL global_timeout: got run still active expected finish before 200000");
        finish_run();
    end

endmodule
